// File: rtl/imem_burst_responder.sv
// Memory-side responder for I-cache line refills: reads BURST_LEN words from a
// synchronous RAM and returns them as a valid/ready beat stream with a last flag.
module imem_burst_responder #(
    parameter int BURST_LEN = 8,
    parameter int RAM_AW    = 12,
    parameter int RSP_DELAY = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_from_cache_rd_req_valid,
    input  logic [31:0]       i_from_cache_rd_req_addr,
    output logic              o_to_cache_rd_req_ready,
    output logic              o_to_cache_rd_rsp_valid,
    output logic [31:0]       o_to_cache_rd_rsp_data,
    output logic              o_to_cache_rd_rsp_last,
    input  logic              i_from_cache_rd_rsp_ready,
    output logic              o_ram_rd_en,
    output logic [RAM_AW-1:0] o_ram_addr,
    input  logic [31:0]       i_ram_rdata
);
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, DELAY, STREAM} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [RAM_AW-1:0] r_base;
    logic [CW-1:0]     r_issued;
    logic [3:0]        r_delayCnt;
    logic              r_inflight;
    logic              r_inflightLast;
    logic [31:0]       r_fifoData [2];
    logic              r_fifoLast [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_fifoCnt;

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_issueLast;
    logic              w_headLast;
    logic [2:0]        w_occupancy;
    logic              w_unused;

    assign w_unused = ^{i_from_cache_rd_req_addr[31:RAM_AW+2], i_from_cache_rd_req_addr[4:0]};

    // Occupancy counts the word still in the RAM pipeline, so the FIFO can never overflow.
    always_comb begin
        w_accept    = (r_state == IDLE) && i_from_cache_rd_req_valid;
        w_pop       = (r_fifoCnt != 2'd0) && i_from_cache_rd_rsp_ready;
        w_push      = r_inflight;
        w_headLast  = r_fifoLast[r_rdPtr];
        w_occupancy = {1'b0, r_fifoCnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue     = (r_state == STREAM) && (r_issued < CW'(BURST_LEN)) && (w_occupancy < 3'd2);
        w_issueLast = (r_issued == CW'(BURST_LEN - 1));
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = (RSP_DELAY > 0) ? DELAY : STREAM;
            DELAY:   if (r_delayCnt == 4'(RSP_DELAY - 1)) w_nextState = STREAM;
            STREAM:  if (w_pop && w_headLast) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_to_cache_rd_req_ready = (r_state == IDLE) && !i_rst;
        o_to_cache_rd_rsp_valid = (r_fifoCnt != 2'd0);
        o_to_cache_rd_rsp_data  = o_to_cache_rd_rsp_valid ? r_fifoData[r_rdPtr] : 32'd0;
        o_to_cache_rd_rsp_last  = o_to_cache_rd_rsp_valid && w_headLast;
        o_ram_rd_en             = w_issue;
        o_ram_addr              = r_base + RAM_AW'(r_issued);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base         <= '0;
            r_issued       <= '0;
            r_delayCnt     <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
            r_wrPtr        <= 1'b0;
            r_rdPtr        <= 1'b0;
            r_fifoCnt      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifoData[i] <= 32'd0;
                r_fifoLast[i] <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_base     <= {i_from_cache_rd_req_addr[RAM_AW+1:5], 3'b000};
                r_issued   <= '0;
                r_delayCnt <= '0;
            end else begin
                if (r_state == DELAY) r_delayCnt <= r_delayCnt + 4'd1;
                if (w_issue)          r_issued   <= r_issued + CW'(1);
            end
            r_inflight     <= w_issue;
            r_inflightLast <= w_issueLast;
            // The RAM word arrives one cycle after its read strobe.
            if (w_push) begin
                r_fifoData[r_wrPtr] <= i_ram_rdata;
                r_fifoLast[r_wrPtr] <= r_inflightLast;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) r_rdPtr <= ~r_rdPtr;
            case ({w_push, w_pop})
                2'b10:   r_fifoCnt <= r_fifoCnt + 2'd1;
                2'b01:   r_fifoCnt <= r_fifoCnt - 2'd1;
                default: r_fifoCnt <= r_fifoCnt;
            endcase
        end
    end

    fifoNoOverflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && !w_pop && (r_fifoCnt == 2'd2)));

endmodule

// File: tb/tb_imem_burst_responder.sv
// Directed bench for imem_burst_responder: three parameterisations share one clock,
// each backed by a synchronous RAM model returning 0xA000_0000 | word address.
module tb_imem_burst_responder;
    localparam int BL = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reqValid [3];
    logic [31:0] reqAddr  [3];
    logic        reqReady [3];
    logic        rspValid [3];
    logic [31:0] rspData  [3];
    logic        rspLast  [3];
    logic        rspReady [3];
    logic        ramEn    [3];
    logic [11:0] ramAddr  [3];
    logic [31:0] ramData  [3];
    logic [11:0] ramAddrA;
    logic [11:0] ramAddrB;
    logic [9:0]  ramAddrC;

    assign ramAddr[0] = ramAddrA;
    assign ramAddr[1] = ramAddrB;
    assign ramAddr[2] = {2'b00, ramAddrC};

    imem_burst_responder #(.BURST_LEN(BL), .RAM_AW(12), .RSP_DELAY(0)) dutFast (
        .i_clk(clk), .i_rst(rst),
        .i_from_cache_rd_req_valid(reqValid[0]), .i_from_cache_rd_req_addr(reqAddr[0]),
        .o_to_cache_rd_req_ready(reqReady[0]), .o_to_cache_rd_rsp_valid(rspValid[0]),
        .o_to_cache_rd_rsp_data(rspData[0]), .o_to_cache_rd_rsp_last(rspLast[0]),
        .i_from_cache_rd_rsp_ready(rspReady[0]), .o_ram_rd_en(ramEn[0]),
        .o_ram_addr(ramAddrA), .i_ram_rdata(ramData[0])
    );

    imem_burst_responder #(.BURST_LEN(BL), .RAM_AW(12), .RSP_DELAY(3)) dutDelay (
        .i_clk(clk), .i_rst(rst),
        .i_from_cache_rd_req_valid(reqValid[1]), .i_from_cache_rd_req_addr(reqAddr[1]),
        .o_to_cache_rd_req_ready(reqReady[1]), .o_to_cache_rd_rsp_valid(rspValid[1]),
        .o_to_cache_rd_rsp_data(rspData[1]), .o_to_cache_rd_rsp_last(rspLast[1]),
        .i_from_cache_rd_rsp_ready(rspReady[1]), .o_ram_rd_en(ramEn[1]),
        .o_ram_addr(ramAddrB), .i_ram_rdata(ramData[1])
    );

    imem_burst_responder #(.BURST_LEN(BL), .RAM_AW(10), .RSP_DELAY(0)) dutNarrow (
        .i_clk(clk), .i_rst(rst),
        .i_from_cache_rd_req_valid(reqValid[2]), .i_from_cache_rd_req_addr(reqAddr[2]),
        .o_to_cache_rd_req_ready(reqReady[2]), .o_to_cache_rd_rsp_valid(rspValid[2]),
        .o_to_cache_rd_rsp_data(rspData[2]), .o_to_cache_rd_rsp_last(rspLast[2]),
        .i_from_cache_rd_rsp_ready(rspReady[2]), .o_ram_rd_en(ramEn[2]),
        .o_ram_addr(ramAddrC), .i_ram_rdata(ramData[2])
    );

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (ramEn[k]) ramData[k] <= 32'hA000_0000 | {20'h0, ramAddr[k]};
    end

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int          sel;
    logic [32:0] beatQ [$];
    logic [11:0] addrQ [$];
    int          accCyc, firstEnCyc, firstValCyc, lastCyc, rdyAfterCyc, acceptCount;
    logic        stall;
    logic [32:0] held;

    task automatic clearMon();
        beatQ.delete();
        addrQ.delete();
        accCyc      = -1;
        firstEnCyc  = -1;
        firstValCyc = -1;
        lastCyc     = -1;
        rdyAfterCyc = -1;
        acceptCount = 0;
        stall       = 1'b0;
    endtask

    // Inputs change 1ns after posedge, so the negedge sees one whole, settled cycle.
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (accCyc >= 0 && lastCyc < 0 && cyc > accCyc)
                checkOutput("reqReadyBusy", reqReady[sel], 0);
            if (reqValid[sel] && reqReady[sel]) begin
                accCyc = cyc;
                acceptCount++;
            end
            if (ramEn[sel]) begin
                addrQ.push_back(ramAddr[sel]);
                if (firstEnCyc < 0) firstEnCyc = cyc;
            end
            if (rspValid[sel] && firstValCyc < 0) firstValCyc = cyc;
            if (stall) begin
                checkOutput("holdValid", rspValid[sel], 1);
                checkOutput("holdBeat", {rspLast[sel], rspData[sel]}, held);
            end
            if (rspValid[sel] && rspReady[sel]) begin
                beatQ.push_back({rspLast[sel], rspData[sel]});
                if (rspLast[sel]) lastCyc = cyc;
            end
            if (reqReady[sel] && lastCyc >= 0 && rdyAfterCyc < 0) rdyAfterCyc = cyc;
            stall = rspValid[sel] && !rspReady[sel];
            held  = {rspLast[sel], rspData[sel]};
        end
    end

    task automatic acceptRequest(input int which, input logic [31:0] addr);
        sel = which;
        clearMon();
        reqAddr[which]  = addr;
        reqValid[which] = 1'b1;
        rspReady[which] = 1'b1;
        for (int t = 0; t < 20 && accCyc < 0; t++) begin
            @(posedge clk); #1;
        end
        reqValid[which] = 1'b0;
    endtask

    // mode 0: rsp_ready held high; mode 1: rsp_ready cycles 1,0,0,1,0,1.
    task automatic applyStimulus(input int which, input logic [31:0] addr, input int mode, input bit pulseBusy);
        logic [5:0] pat;
        pat = 6'b101001;
        acceptRequest(which, addr);
        for (int t = 0; t < 300 && lastCyc < 0; t++) begin
            if (mode == 1) rspReady[which] = pat[t % 6];
            if (pulseBusy) begin
                reqValid[which] = (t % 3 == 1);
                reqAddr[which]  = 32'h0000_0200;
            end
            @(posedge clk); #1;
        end
        reqValid[which] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rspReady[which] = 1'b0;
    endtask

    task automatic checkBurst(input logic [11:0] expBase, input int delay, input bit fullRate);
        logic [11:0] a;
        checkOutput("accepted", accCyc >= 0, 1);
        checkOutput("acceptCount", acceptCount, 1);
        checkOutput("beatCount", beatQ.size(), BL);
        checkOutput("issueCount", addrQ.size(), BL);
        for (int i = 0; i < BL; i++) begin
            a = expBase + 12'(i);
            if (i < addrQ.size()) checkOutput("ramAddr", addrQ[i], a);
            if (i < beatQ.size()) begin
                checkOutput("beatData", beatQ[i][31:0], 32'hA000_0000 | {20'h0, a});
                checkOutput("beatLast", beatQ[i][32], i == BL - 1);
            end
        end
        checkOutput("firstRdEn", firstEnCyc - accCyc, 1 + delay);
        checkOutput("firstValid", firstValCyc - accCyc, 3 + delay);
        if (fullRate) checkOutput("burstDone", lastCyc - accCyc, 2 + delay + BL);
        checkOutput("reqReadyBack", rdyAfterCyc - lastCyc, 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "ReqReady"}, reqReady[0], 0);
        checkOutput({tag, "RspValid"}, rspValid[0], 0);
        checkOutput({tag, "RspLast"}, rspLast[0], 0);
        checkOutput({tag, "RspData"}, rspData[0], 0);
        checkOutput({tag, "RamEn"}, ramEn[0], 0);
        checkOutput({tag, "RamAddr"}, ramAddr[0], 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            reqValid[k] = 1'b0;
            reqAddr[k]  = 32'd0;
            rspReady[k] = 1'b0;
        end
        sel = 0;
        clearMon();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkResetOutputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idleReqReady0", reqReady[0], 1);
        checkOutput("idleReqReady1", reqReady[1], 1);
        checkOutput("idleReqReady2", reqReady[2], 1);

        $display("[TB] aligned burst 0x40, full rate");
        applyStimulus(0, 32'h0000_0040, 0, 1'b0);
        checkBurst(12'h010, 0, 1'b1);

        $display("[TB] unaligned burst 0x5C");
        applyStimulus(0, 32'h0000_005C, 0, 1'b0);
        checkBurst(12'h010, 0, 1'b1);

        $display("[TB] burst 0x40 with backpressure");
        applyStimulus(0, 32'h0000_0040, 1, 1'b0);
        checkBurst(12'h010, 0, 1'b0);

        $display("[TB] RSP_DELAY=3 with request pulses while busy");
        applyStimulus(1, 32'h0000_0040, 0, 1'b1);
        checkBurst(12'h010, 3, 1'b1);

        $display("[TB] reset after third beat");
        acceptRequest(0, 32'h0000_0080);
        for (int t = 0; t < 50 && beatQ.size() < 3; t++) begin
            @(posedge clk); #1;
        end
        checkOutput("beatsBeforeReset", beatQ.size(), 3);
        rst = 1'b1;
        #1;
        checkResetOutputs("midReset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clearMon();
        repeat (4) begin
            @(posedge clk); #1;
        end
        rspReady[0] = 1'b0;
        checkOutput("beatsAfterReset", beatQ.size(), 0);
        checkOutput("issuesAfterReset", addrQ.size(), 0);
        applyStimulus(0, 32'h0000_0100, 0, 1'b0);
        checkBurst(12'h040, 0, 1'b1);

        $display("[TB] RAM_AW=10 address truncation");
        applyStimulus(2, 32'h0000_1FE0, 0, 1'b0);
        checkBurst(12'h3F8, 0, 1'b1);
        applyStimulus(2, 32'h0000_1000, 0, 1'b0);
        checkBurst(12'h000, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
